// File: rtl/vending_sequencer_pkg.sv
// Shared definitions for the vending sequencer: denominations, prices,
// default sizing and the FSM state encoding.
package vending_machine_def;

    localparam int kNumCoinsDef   = 3;
    localparam int kNumItemsDef   = 4;
    localparam int kTotalBitsDef  = 31;
    localparam int kWaitTimeDef   = 10;
    localparam int kMaxBalanceDef = 10000;

    // Smallest coin; below this nothing more can be returned.
    localparam int kMinCoinValue  = 100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    // Denominations must stay in ascending order for the greedy change picker.
    function automatic int unsigned coin_value(input int idx);
        case (idx)
            0:       return 100;
            1:       return 500;
            2:       return 1000;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned item_price(input int idx);
        case (idx)
            0:       return 400;
            1:       return 500;
            2:       return 1000;
            3:       return 2000;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vending_sequencer_change_picker.sv
// Greedy change selection: one-hot of the largest coin not exceeding the
// balance, or zero when the balance is below the smallest coin.
module change_picker
    import vending_machine_def::*;
#(
    parameter int kNumCoins  = kNumCoinsDef,
    parameter int kTotalBits = kTotalBitsDef
) (
    input  logic [kTotalBits-1:0] i_balance,
    output logic [kNumCoins-1:0]  o_coin
);

    // Ascending denominations: the last fitting coin is the largest one.
    always_comb begin
        o_coin = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (kTotalBits'(coin_value(i)) <= i_balance) begin
                o_coin    = '0;
                o_coin[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_sequencer.sv
// Vending machine sequencer: coin accumulation, item dispense, idle timeout
// and coin-by-coin change return.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no session; only coin inserts are accepted
// ST_ACTIVE | session open; coins, selects and return request accepted
// ST_RETURN | returning change one coin per cycle; all inputs ignored
module vending_sequencer
    import vending_machine_def::*;
#(
    parameter int kNumCoins   = kNumCoinsDef,
    parameter int kNumItems   = kNumItemsDef,
    parameter int kTotalBits  = kTotalBitsDef,
    parameter int kWaitTime   = kWaitTimeDef,
    parameter int kMaxBalance = kMaxBalanceDef
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [kNumCoins-1:0]  i_input_coin,
    input  logic [kNumItems-1:0]  i_select_item,
    input  logic                  i_trigger_return,
    output logic [kNumItems-1:0]  o_available_item,
    output logic [kNumItems-1:0]  o_output_item,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic                  o_coin_reject,
    output logic [kTotalBits-1:0] o_balance,
    output logic                  o_busy
);

    localparam int kTimerBits = (kWaitTime < 2) ? 1 : $clog2(kWaitTime + 1);

    typedef logic [kTotalBits-1:0] bal_t;

    localparam logic [kTimerBits-1:0] kReload  = kTimerBits'(kWaitTime);
    localparam logic [kTotalBits:0]   kMaxWide = (kTotalBits + 1)'(kMaxBalance);

    state_t                state_q, state_d;
    bal_t                  balance_q, balance_d;
    logic [kTimerBits-1:0] timer_q, timer_d;
    logic [kNumItems-1:0]  output_item_q, output_item_d;
    logic [kNumCoins-1:0]  return_coin_q, return_coin_d;
    logic                  coin_reject_q, coin_reject_d;

    logic [kNumCoins-1:0]  change_coin;
    bal_t                  change_value;
    bal_t                  coin_sum;
    logic [kTotalBits:0]   coin_total;
    logic                  sel_found;
    logic [kNumItems-1:0]  sel_onehot;
    bal_t                  sel_price;

    change_picker #(
        .kNumCoins  (kNumCoins),
        .kTotalBits (kTotalBits)
    ) u_change_picker (
        .i_balance (balance_q),
        .o_coin    (change_coin)
    );

    always_comb begin
        coin_sum     = '0;
        change_value = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (i_input_coin[i]) coin_sum = coin_sum + bal_t'(coin_value(i));
            if (change_coin[i])  change_value = change_value | bal_t'(coin_value(i));
        end
        // One extra bit so an over-ceiling insert cannot wrap and slip through.
        coin_total = {1'b0, balance_q} + {1'b0, coin_sum};
    end

    always_comb begin
        sel_found  = 1'b0;
        sel_onehot = '0;
        sel_price  = '0;
        for (int i = kNumItems - 1; i >= 0; i--) begin
            if (i_select_item[i]) begin
                sel_found     = 1'b1;
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_price     = bal_t'(item_price(i));
            end
        end
    end

    always_comb begin
        o_available_item = '0;
        if (state_q == ST_ACTIVE) begin
            for (int i = 0; i < kNumItems; i++) begin
                o_available_item[i] = (bal_t'(item_price(i)) <= balance_q);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        balance_d     = balance_q;
        timer_d       = timer_q;
        output_item_d = '0;
        return_coin_d = '0;
        coin_reject_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (|i_input_coin) begin
                    state_d = ST_ACTIVE;
                    timer_d = kReload;
                    if (coin_total > kMaxWide) coin_reject_d = 1'b1;
                    else                       balance_d     = coin_total[kTotalBits-1:0];
                end else if (state_q == ST_ACTIVE) begin
                    // A present select blocks the return request even when unaffordable.
                    if (sel_found && (sel_price <= balance_q)) begin
                        output_item_d = sel_onehot;
                        balance_d     = balance_q - sel_price;
                        timer_d       = kReload;
                    end else if (!sel_found && i_trigger_return) begin
                        state_d = ST_RETURN;
                        timer_d = '0;
                    end else if (timer_q <= kTimerBits'(1)) begin
                        state_d = ST_RETURN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - kTimerBits'(1);
                    end
                end
            end
            ST_RETURN: begin
                if (|change_coin) begin
                    return_coin_d = change_coin;
                    balance_d     = balance_q - change_value;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            balance_q     <= '0;
            timer_q       <= '0;
            output_item_q <= '0;
            return_coin_q <= '0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            balance_q     <= balance_d;
            timer_q       <= timer_d;
            output_item_q <= output_item_d;
            return_coin_q <= return_coin_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign o_output_item = output_item_q;
    assign o_return_coin = return_coin_q;
    assign o_coin_reject = coin_reject_q;
    assign o_balance     = balance_q;
    assign o_busy        = (state_q == ST_RETURN);

endmodule

// File: doc/vending_sequencer.md
VENDING_SEQUENCER -- requirements
Module: vending_sequencer

Interface
REQ-001 SHALL have parameter kNumCoins, default 3, number of coin denominations.
REQ-002 SHALL have parameter kNumItems, default 4, number of items.
REQ-003 SHALL have parameter kTotalBits, default 31, balance width.
REQ-004 SHALL have parameter kWaitTime, default 10, idle cycles before automatic change return.
REQ-005 SHALL have parameter kMaxBalance, default 10000, balance ceiling.
REQ-006 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-008 SHALL have port i_input_coin, input, kNumCoins, coin-insert strobes, bit i = coin i.
REQ-009 SHALL have port i_select_item, input, kNumItems, item-select strobes.
REQ-010 SHALL have port i_trigger_return, input, 1, user change-return request.
REQ-011 SHALL have port o_available_item, output, kNumItems, bit i high when item i is affordable.
REQ-012 SHALL have port o_output_item, output, kNumItems, one-cycle one-hot dispense pulse.
REQ-013 SHALL have port o_return_coin, output, kNumCoins, one-hot coin returned this cycle.
REQ-014 SHALL have port o_coin_reject, output, 1, one-cycle pulse when an insert is refused.
REQ-015 SHALL have port o_balance, output, kTotalBits, registered current balance.
REQ-016 SHALL have port o_busy, output, 1, high while in RETURN.

Function
REQ-017 SHALL use coin values 100/500/1000 and item prices 400/500/1000/2000, index 0 first.
REQ-018 SHALL implement FSM states IDLE, ACTIVE, RETURN.
REQ-019 SHALL give same-cycle event priority: coin > select > return; lower-priority events that cycle are dropped.
REQ-020 In IDLE/ACTIVE, a coin event SHALL add the sum of all asserted coin values to balance next cycle, enter ACTIVE, and reload timer to kWaitTime.
REQ-021 A coin event whose sum would push balance above kMaxBalance SHALL leave balance unchanged and pulse o_coin_reject next cycle; the timer still reloads.
REQ-022 In ACTIVE, a select event SHALL consider only the lowest-index asserted bit.
REQ-023 If that item's price <= balance, o_output_item SHALL pulse that bit next cycle, balance SHALL drop by the price, and timer SHALL reload.
REQ-024 If that item's price > balance, the select SHALL be ignored with no reload; in IDLE, selects are always ignored.
REQ-025 In ACTIVE, each cycle without an accepted coin or select SHALL decrement the timer.
REQ-026 Timer reaching 0, or i_trigger_return accepted in ACTIVE, SHALL enter RETURN next cycle.
REQ-027 In RETURN, each cycle SHALL emit the one-hot largest coin <= balance on o_return_coin (registered, one per cycle) and subtract it.
REQ-028 When balance < 100, the FSM SHALL go to IDLE with o_return_coin = 0; all inputs are ignored in RETURN.
REQ-029 i_trigger_return in IDLE SHALL be ignored.
REQ-030 o_available_item SHALL be combinational from the registered balance and state, forced to 0 in IDLE and RETURN.
REQ-031 Arithmetic SHALL be unsigned at kTotalBits; balance SHALL never underflow.

Reset
REQ-032 reset high at a clock edge SHALL force IDLE, balance 0, timer 0, and all outputs 0, overriding any in-flight event or RETURN.

Structure
REQ-033 Coin values, item prices, kWaitTime, kMaxBalance, and state encodings SHALL live in the shared vending_machine_def package.
REQ-034 Greedy coin selection SHALL be a combinational sub-module change_picker (balance in, one-hot coin out).

Verification
REQ-035 Insert 1000 -> o_balance 1000 next cycle, o_available_item = 0111.
REQ-036 Balance 1000, select 0010 -> o_output_item 0010 for one cycle, o_balance 500.
REQ-037 Balance 1600, i_trigger_return -> o_return_coin 100, 010, 001 on consecutive cycles, then IDLE with balance 0.
REQ-038 Insert 500 then 10 idle cycles -> RETURN entered, coin 010 returned, o_busy high for its duration.
REQ-039 Balance 9500, insert 1000 -> o_coin_reject pulse, balance stays 9500; same-cycle coin and select -> only the coin is applied.
REQ-040 reset asserted mid-RETURN with balance 1500 -> next cycle IDLE, balance 0, o_return_coin 0.
